// File: rtl/cpu_pkg.sv
// Shared CPU constants and the sequential divider FSM encoding.
package cpu_pkg;

   localparam int CPU_XLEN = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it did not borrow.
module div_step
   import cpu_pkg::*;
#(
   parameter int WIDTH = CPU_XLEN
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted = {rem_i, quo_i[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_i};

   // rem_i < dvs_i keeps shifted below 2*dvs_i, so a clear top bit means no borrow
   assign rem_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider (signed; unsigned DIVU support when
// DIVIDER_UNSIGNED_EN is defined, which adds the div_signed port).
module seq_divider
   import cpu_pkg::*;
#(
   parameter int WIDTH = CPU_XLEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_UNSIGNED_EN
   input  logic             div_signed,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             fix_ph_q, fix_ph_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;

   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             sgn_en;
   logic             dvd_neg;
   logic             dvs_neg;

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

`ifdef DIVIDER_UNSIGNED_EN
   assign sgn_en = div_signed;
`else
   assign sgn_en = 1'b1;
`endif

   assign dvd_neg = sgn_en & dividend[WIDTH-1];
   assign dvs_neg = sgn_en & divisor[WIDTH-1];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      zero_d      = zero_q;
      fix_ph_d    = fix_ph_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;

      case (state_q)
         DIV_IDLE: begin
            if (div_start) begin
               if (divisor == '0) begin
                  zero_d  = 1'b1;
                  state_d = DIV_DONE;
               end else begin
                  zero_d    = 1'b0;
                  fix_ph_d  = 1'b0;
                  rem_d     = '0;
                  quo_d     = apply_sign(dividend, dvd_neg);
                  dvs_d     = apply_sign(divisor, dvs_neg);
                  neg_quo_d = dvd_neg ^ dvs_neg;
                  neg_rem_d = dvd_neg;
                  cnt_d     = CNT_W'(WIDTH - 1);
                  state_d   = DIV_RUN;
               end
            end
         end
         DIV_RUN: begin
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q == '0) begin
               state_d = DIV_FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DIV_FIX: begin
            // Negation and output load are split across two cycles so the
            // adder never sits in front of the architectural result registers.
            if (!fix_ph_q) begin
               quo_d    = apply_sign(quo_q, neg_quo_q);
               rem_d    = apply_sign(rem_q, neg_rem_q);
               fix_ph_d = 1'b1;
            end else begin
               quotient_d  = quo_q;
               remainder_d = rem_q;
               state_d     = DIV_DONE;
            end
         end
         DIV_DONE: begin
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= DIV_IDLE;
         cnt_q       <= '0;
         zero_q      <= 1'b0;
         fix_ph_q    <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         zero_q      <= zero_d;
         fix_ph_q    <= fix_ph_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   // Working datapath registers are always reloaded on acceptance.
   always_ff @(posedge clk) begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
   end

   assign busy      = (state_q != DIV_IDLE);
   assign done      = (state_q == DIV_DONE);
   assign div_zero  = (state_q == DIV_DONE) && zero_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: random and directed divisions checked
// against a plain-arithmetic reference model, plus reset-abort behaviour.
module tb_seq_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         div_start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         div_signed = 1'b1;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           start;
      int           lat;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] last_q = '0;
   logic [W-1:0] last_r = '0;
   logic [W-1:0] hold_q = '0;
   logic [W-1:0] hold_r = '0;

   seq_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .div_start (div_start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef DIVIDER_UNSIGNED_EN
      .div_signed(div_signed),
`endif
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse, otherwise checks hold.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         sb.delete();
         hold_q = '0;
         hold_r = '0;
      end else if (done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_zero", {31'b0, div_zero}, {31'b0, e.z});
            chk("latency", W'(cyc - e.start), W'(e.lat));
            hold_q = e.q;
            hold_r = e.r;
         end
      end else begin
         chk("hold_quotient", quotient, hold_q);
         chk("hold_remainder", remainder, hold_r);
         chk("div_zero_idle", {31'b0, div_zero}, 32'd0);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input bit poke);
      exp_t         e;
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           sa;
      int           sd;
      wait_idle();
      dividend   = a;
      divisor    = b;
      div_signed = sgn;
      div_start  = 1'b1;
      if (b == '0) begin
         q = last_q;
         r = last_r;
      end else if (sgn) begin
         sa = a;
         sd = b;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
         end else begin
            q = W'(sa / sd);
            r = W'(sa % sd);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      last_q  = q;
      last_r  = r;
      e.q     = q;
      e.r     = r;
      e.z     = (b == '0);
      e.start = cyc;
      e.lat   = (b == '0) ? 1 : W + 3;
      sb.push_back(e);
      @(posedge clk); #1;
      div_start = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      if (poke && b != '0) begin
         repeat (4) begin @(posedge clk); #1; end
         div_start = 1'b1;
         dividend  = $urandom;
         divisor   = $urandom_range(0, 1);
         @(posedge clk); #1;
         div_start = 1'b0;
      end
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sgn;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);

      do_div(32'd100, 32'd7, 1'b1, 1'b0);
      do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      do_div(32'd5, 32'd0, 1'b1, 1'b0);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_div(32'd1234567, 32'hFFFF_FFF0, 1'b1, 1'b1);
`ifdef DIVIDER_UNSIGNED_EN
      do_div(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
`endif

      // Abort a division with reset at RUN cycle 10, ignored start at cycle 5.
      wait_idle();
      dividend  = 32'd1000;
      divisor   = 32'd3;
      div_signed = 1'b1;
      div_start = 1'b1;
      @(posedge clk); #1;
      div_start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      div_start = 1'b1;
      dividend  = 32'd77;
      divisor   = 32'd0;
      @(posedge clk); #1;
      div_start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("busy_before_abort", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_div_zero", {31'b0, div_zero}, 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      last_q = '0;
      last_r = '0;
      repeat (W + 5) @(posedge clk);
      #1;
      chk("abort_stays_idle", {31'b0, busy}, 32'd0);

      do_div(32'd9, 32'd0, 1'b1, 1'b0);

      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = W'($urandom_range(1, 15));
            3: begin
               a = 32'h8000_0000;
               b = $urandom;
            end
            default: b = $urandom;
         endcase
`ifdef DIVIDER_UNSIGNED_EN
         sgn = 1'($urandom_range(0, 1));
`else
         sgn = 1'b1;
`endif
         do_div(a, b, sgn, (i % 7) == 3);
      end

      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", W'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  reset is synchronous and active-high.
REQ-004 SHALL have port div_start  in  1  request pulse from control unit; sampled only in IDLE.
REQ-005 SHALL have port dividend  in  WIDTH  operand A, captured on accepted div_start.
REQ-006 SHALL have port divisor  in  WIDTH  operand B, captured on accepted div_start.
REQ-007 SHALL have port div_signed  in  1  1 = signed DIV, 0 = DIVU; present only with DIVIDER_UNSIGNED_EN.
REQ-008 SHALL have port busy  out  1  high in every non-IDLE state.
REQ-009 SHALL have port done  out  1  one-cycle pulse; results valid from this cycle on.
REQ-010 SHALL have port div_zero  out  1  one-cycle pulse coincident with done when divisor was 0.
REQ-011 SHALL have port quotient  out  WIDTH  result for LO.
REQ-012 SHALL have port remainder  out  WIDTH  result for HI.

Function
REQ-013 SHALL implement FSM IDLE, RUN, FIX, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-014 SHALL, in IDLE with div_start=1 and divisor!=0: capture operand magnitudes and signs, load iteration counter with WIDTH-1, go to RUN.
REQ-015 SHALL, in IDLE with div_start=1 and divisor==0: go directly to DONE; done=1, div_zero=1; quotient/remainder keep previous values.
REQ-016 SHALL, in RUN, perform one restoring shift-subtract step per cycle; exactly WIDTH cycles, then FIX.
REQ-017 SHALL, in FIX, apply signs and register quotient/remainder, then go to DONE.
REQ-018 SHALL assert done exactly WIDTH+3 cycles after the div_start sampling edge (35 for WIDTH=32); div_zero case exactly 1 cycle.
REQ-019 SHALL produce signed results truncated toward zero, remainder carrying the dividend's sign.
REQ-020 SHALL, for most-negative / -1, produce quotient=dividend, remainder=0, no flag.
REQ-021 SHALL ignore div_start while busy=1; captured operands unaffected by input changes after acceptance.
REQ-022 SHALL hold quotient/remainder stable between done pulses.
REQ-023 SHALL accept div_start in the IDLE cycle immediately after DONE (back-to-back).

Reset
REQ-024 SHALL, on reset=1 at a clock edge in any state, go to IDLE with busy=0, done=0, div_zero=0, quotient=0, remainder=0, counter=0.
REQ-025 SHALL NOT emit done for an operation aborted by reset.

Configuration
REQ-026 SHALL, with DIVIDER_UNSIGNED_EN defined, add div_signed; div_signed=0 treats operands as unsigned with no sign fix in FIX.
REQ-027 SHALL, without DIVIDER_UNSIGNED_EN, omit div_signed and always divide signed; latency unchanged either way.

Structure
REQ-028 SHALL take its FSM state encoding and the default width constant from shared package cpu_pkg.
REQ-029 SHALL place one combinational restoring step (shift, trial subtract, select) in sub-module div_step.

Verification
REQ-030 SHALL cover: dividend=100, divisor=7 -> done at cycle 35, quotient=14, remainder=2, div_zero=0.
REQ-031 SHALL cover: -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-032 SHALL cover: 5 / 0 -> done and div_zero high 1 cycle after start; outputs equal prior result.
REQ-033 SHALL cover: 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0.
REQ-034 SHALL cover: reset at RUN cycle 10 -> busy=0 next cycle, outputs 0, no done; second div_start at RUN cycle 5 ignored.
REQ-035 SHALL cover, with DIVIDER_UNSIGNED_EN and div_signed=0: 0xFFFFFFFF / 2 -> quotient=0x7FFFFFFF, remainder=1.
